pc_sequenciador: RTL
====================

# pc_sequenciador

Program-counter sequencer for the MIPS processor. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It presents the fetched word to the control unit, then waits for that unit's flow decision. It then loads the next PC from one of four sources: sequential, taken branch, `j`/`jal` jump target, or `jr` register. It sits between instruction memory, the control unit and the register file. It replaces free-running PC+4 logic with an explicit multicycle fetch controller.

## Interface
- `VETOR_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `VETOR_EXCECAO`, default 32'h0000_0080: PC value loaded on a misaligned `jr`. Used only with `PC_EXCECAO_EN`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `busca_req`  out  1  fetch request to instruction memory.
- `busca_end`  out  32  fetch address; always equals `pc`.
- `busca_ack`  in  1  memory accepted the request; `instrucao` is valid in the same cycle.
- `instrucao`  in  32  instruction word from memory.
- `instr_out`  out  32  latched instruction for the control unit and decoder.
- `instr_valida`  out  1  high while in DECOD.
- `decisao_valida`  in  1  control unit has resolved flow for the current instruction.
- `tipo_salto`  in  2  flow type: 00 sequential, 01 branch, 10 jump, 11 `jr`.
- `cond_desvio`  in  1  branch condition true; meaningful only when `tipo_salto`=01.
- `reg_destino`  in  32  rs register value for `jr`.
- `pc`  out  32  current PC.
- `pc_mais4`  out  32  `pc`+4, used for the `jal` link value.
- `excecao`  out  1  one-cycle pulse on a misaligned `jr` (only with `PC_EXCECAO_EN`; tied to 0 otherwise).

## Operation
- The FSM has three states: INICIO, BUSCA, DECOD.
- **INICIO**
  - `busca_req`=0.
  - Always moves to BUSCA on the next cycle.
- **BUSCA**
  - `busca_req`=1 and `busca_end`=`pc`, both held stable until `busca_ack`.
  - On `busca_ack`=1: `instr_out`←`instrucao`, then move to DECOD.
- **DECOD**
  - `busca_req`=0 and `instr_valida`=1.
  - The FSM stays in DECOD until `decisao_valida`=1.
  - When `decisao_valida`=1: `pc`←next PC, then move to BUSCA.
- **Next-PC rules** (p4 = `pc`+4, 32-bit, wraps modulo 2^32):
  - 00: p4.
  - 01: if `cond_desvio`, p4 + (sign-extended `instr_out[15:0]` << 2), modulo 2^32; otherwise p4.
  - 10: {p4[31:28], `instr_out[25:0]`, 2'b00}.
  - 11: `reg_destino`. Misaligned-target handling is described under Configuration.
- **Ignored inputs:**
  - `busca_ack` outside BUSCA.
  - `decisao_valida` outside DECOD.
  - `tipo_salto`, `cond_desvio` and `reg_destino` are sampled only in the cycle where `decisao_valida`=1 in DECOD.
- **Reset values:**
  - State = INICIO, `pc`=`VETOR_RESET`.
  - `instr_out`=32'h0000_0000.
  - `busca_req`=0, `instr_valida`=0, `excecao`=0.

## Timing
- All outputs are registered or decoded from the state alone (Moore); no combinational path from inputs to `busca_req` or `instr_valida`.
- **Minimum rate:** 2 cycles per instruction, when the ack arrives in the first BUSCA cycle and the decision in the first DECOD cycle.
- **PC update:** the new `pc` is visible in the cycle after `decisao_valida`, which is also the first cycle of the next BUSCA.
- **Reset asserted mid-fetch or mid-decode:**
  - `busca_req` and `instr_valida` drop immediately (asynchronous).
  - `pc` returns to `VETOR_RESET`.
  - The pending ack or decision is discarded.
- **Wrap-around:** from `pc`=32'hFFFF_FFFC, sequential flow gives 32'h0000_0000; no flag is raised.

## Configuration
- Macro: `PC_EXCECAO_EN`.
- **Defined:**
  - A `jr` with `reg_destino[1:0]`≠0 loads `VETOR_EXCECAO` into `pc`.
  - `excecao` pulses for exactly one cycle, the cycle after the decision.
- **Undefined:**
  - A `jr` loads {`reg_destino[31:2]`, 2'b00}.
  - `excecao` is a constant 0.

## Structure
- **Shared package `mips_pkg`:**
  - FSM state enum (INICIO, BUSCA, DECOD).
  - `tipo_salto` encodings (SALTO_SEQ, SALTO_BRANCH, SALTO_JUMP, SALTO_JR).
  - Default reset and exception vectors.
- **Sub-module `calc_destino`:** purely combinational. Inputs are `pc`, `instr_out`, `tipo_salto`, `cond_desvio` and `reg_destino`. Outputs are the next PC and a misaligned flag. It absorbs the jump-address and branch-offset shift logic.

## Test plan
- **Reset:** release reset, memory acks immediately → `busca_req` goes high on cycle 2 with `busca_end`=0x0000_0000.
- **Sequential, with memory wait:** ack 3 cycles late, decision 00 → `busca_req` held with the address stable for 3 cycles; next `busca_end`=0x0000_0004.
- **Branch:** `pc`=0x0000_0010, `instr_out[15:0]`=16'hFFFE, type 01.
  - `cond_desvio`=1 → next `pc`=0x0000_000C.
  - `cond_desvio`=0 → next `pc`=0x0000_0014.
- **Jump:** `pc`=0x4000_0100, `instr_out[25:0]`=26'h000_0040, type 10 → next `pc`=0x4000_0100.
- **Misaligned `jr`:** `reg_destino`=0x0000_0203.
  - With the macro → `pc`=0x0000_0080 and a single-cycle `excecao` pulse.
  - Without the macro → `pc`=0x0000_0200.
- **Reset mid-DECOD, plus stray decision:** assert reset while in DECOD → `instr_valida` drops immediately and `pc`=`VETOR_RESET`. A `decisao_valida` pulse during BUSCA → ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and default vectors for the MIPS PC sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    DECOD  = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    SALTO_SEQ    = 2'b00,
    SALTO_BRANCH = 2'b01,
    SALTO_JUMP   = 2'b10,
    SALTO_JR     = 2'b11
  } tipo_salto_t;

  localparam logic [31:0] VETOR_RESET_PADRAO   = 32'h0000_0000;
  localparam logic [31:0] VETOR_EXCECAO_PADRAO = 32'h0000_0080;

  // Branch immediate, sign-extended and scaled to a byte offset.
  function automatic logic [31:0] desloc_desvio(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequenciador_if.sv
// ============================================================================
// pc_sequenciador_if : fetch bus and control-unit decision signals
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_sequenciador_if;
  logic        busca_req;
  logic [31:0] busca_end;
  logic        busca_ack;
  logic [31:0] instrucao;
  logic [31:0] instr_out;
  logic        instr_valida;
  logic        decisao_valida;
  logic [1:0]  tipo_salto;
  logic        cond_desvio;
  logic [31:0] reg_destino;
  logic [31:0] pc;
  logic [31:0] pc_mais4;
  logic        excecao;

  modport master (
    output busca_req, busca_end, instr_out, instr_valida, pc, pc_mais4, excecao,
    input  busca_ack, instrucao, decisao_valida, tipo_salto, cond_desvio, reg_destino
  );

  modport slave (
    input  busca_req, busca_end, instr_out, instr_valida, pc, pc_mais4, excecao,
    output busca_ack, instrucao, decisao_valida, tipo_salto, cond_desvio, reg_destino
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequenciador_calc_destino.sv
// ============================================================================
// calc_destino : combinational next-PC computation (seq / branch / j / jr)
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_destino
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_out,
  input  logic [1:0]  tipo_salto,
  input  logic        cond_desvio,
  input  logic [31:0] reg_destino,
  output logic [31:0] pc_prox,
  output logic        desalinhado
);

  logic [31:0] p4;

  always_comb begin
    p4          = pc + 32'd4;
    pc_prox     = p4;
    desalinhado = 1'b0;
    case (tipo_salto_t'(tipo_salto))
      SALTO_SEQ:    pc_prox = p4;
      SALTO_BRANCH: if (cond_desvio) pc_prox = p4 + desloc_desvio(instr_out[15:0]);
      SALTO_JUMP:   pc_prox = {p4[31:28], instr_out[25:0], 2'b00};
      SALTO_JR: begin
        pc_prox     = {reg_destino[31:2], 2'b00};
        desalinhado = |reg_destino[1:0];
      end
      default:      pc_prox = p4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequenciador.sv
// ============================================================================
// pc_sequenciador : multicycle PC sequencer (INICIO -> BUSCA -> DECOD).
// Optional macro PC_EXCECAO_EN: misaligned jr traps to VETOR_EXCECAO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequenciador
  import mips_pkg::*;
#(
  parameter logic [31:0] VETOR_RESET   = VETOR_RESET_PADRAO,
  parameter logic [31:0] VETOR_EXCECAO = VETOR_EXCECAO_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  pc_sequenciador_if.master  bus
);

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        excecao_q, excecao_d;
  logic [31:0] pc_prox;
  logic [31:0] pc_alvo;
  logic        desalinhado;
  logic        evento_exc;

  calc_destino u_calc_destino (
    .pc          (pc_q),
    .instr_out   (instr_q[25:0]),
    .tipo_salto  (bus.tipo_salto),
    .cond_desvio (bus.cond_desvio),
    .reg_destino (bus.reg_destino),
    .pc_prox     (pc_prox),
    .desalinhado (desalinhado)
  );

`ifdef PC_EXCECAO_EN
  assign pc_alvo    = desalinhado ? VETOR_EXCECAO : pc_prox;
  assign evento_exc = desalinhado;
`else
  // Without the trap, jr simply drops the low address bits.
  assign pc_alvo    = pc_prox;
  assign evento_exc = 1'b0;
  logic unused_sinais;
  assign unused_sinais = &{1'b0, VETOR_EXCECAO, desalinhado};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= INICIO;
      pc_q      <= VETOR_RESET;
      instr_q   <= 32'h0000_0000;
      excecao_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      excecao_q <= excecao_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    excecao_d = 1'b0;
    case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        if (bus.busca_ack) begin
          instr_d  = bus.instrucao;
          estado_d = DECOD;
        end
      end
      DECOD: begin
        if (bus.decisao_valida) begin
          pc_d      = pc_alvo;
          excecao_d = evento_exc;
          estado_d  = BUSCA;
        end
      end
      default: estado_d = INICIO;
    endcase
  end

  // Handshake outputs decode from state only, so no input reaches them combinationally.
  assign bus.busca_req    = (estado_q == BUSCA);
  assign bus.instr_valida = (estado_q == DECOD);
  assign bus.busca_end    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.pc_mais4     = pc_q + 32'd4;
  assign bus.instr_out    = instr_q;
  assign bus.excecao      = excecao_q;

endmodule

`default_nettype wire
